// File: rtl/dbg_halt_ctrl_pkg.sv
// Shared types and constants for the debug halt sequencer.
// Cause codes match the dcsr.cause encoding seen by the debugger.
package dbg_halt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } dbg_state_e;

    localparam logic [2:0] DBG_CAUSE_NONE    = 3'd0;
    localparam logic [2:0] DBG_CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] DBG_CAUSE_TRIGGER = 3'd2;
    localparam logic [2:0] DBG_CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] DBG_CAUSE_STEP    = 3'd4;

    localparam int DBG_DRAIN_MAX_DEF = 16;

endpackage

// File: rtl/dbg_halt_ctrl.sv
// Debug-mode entry/exit sequencer: flush, drain, halt, resume, step.
// dpc/dcsr.cause are captured on entry; dpc is CSR-writable while halted.
module dbg_halt_ctrl
    import dbg_halt_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DRAIN_MAX  = DBG_DRAIN_MAX_DEF
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  breakpoint,
    input  logic                  ebreak_ex,
    input  logic                  haltreq,
    input  logic                  resumereq,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  pipe_idle,
    input  logic                  instr_retire,
    input  logic                  dpc_wr_en,
    input  logic [ADDR_WIDTH-1:0] dpc_wr_data,
    output logic                  dbg_mode,
    output logic                  halted,
    output logic                  resumeack,
    output logic                  pipe_flush,
    output logic                  pc_redirect,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] dpc,
    output logic [2:0]            dcsr_cause
);

    localparam int CW = $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);

    dbg_state_e            state_q;
    logic [CW-1:0]         cnt_q;
    logic                  dbg_q;
    logic                  ack_q;
    logic                  flush_q;
    logic                  redir_q;
    logic [ADDR_WIDTH-1:0] dpc_q;
    logic [2:0]            cause_q;

    logic                  hit;
    logic [2:0]            sel_cause;
    logic [ADDR_WIDTH-1:0] sel_pc;
    logic                  in_step;

    assign in_step = (state_q == ST_STEP);

    // Halt-cause priority; while stepping a retire outranks haltreq.
    always_comb begin
        hit       = 1'b0;
        sel_cause = DBG_CAUSE_NONE;
        sel_pc    = pc_next;
        if (breakpoint) begin
            hit       = 1'b1;
            sel_cause = DBG_CAUSE_TRIGGER;
            sel_pc    = pc_ex;
        end else if (ebreak_ex) begin
            hit       = 1'b1;
            sel_cause = DBG_CAUSE_EBREAK;
            sel_pc    = pc_ex;
        end else if (in_step && instr_retire) begin
            hit       = 1'b1;
            sel_cause = DBG_CAUSE_STEP;
        end else if (haltreq) begin
            hit       = 1'b1;
            sel_cause = DBG_CAUSE_HALTREQ;
        end
    end

    // Sequencer FSM with registered status and one-cycle pulses.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            dbg_q   <= 1'b0;
            ack_q   <= 1'b0;
            flush_q <= 1'b0;
            redir_q <= 1'b0;
            dpc_q   <= '0;
            cause_q <= DBG_CAUSE_NONE;
        end else begin
            ack_q   <= 1'b0;
            flush_q <= 1'b0;
            redir_q <= 1'b0;
            case (state_q)
                ST_RUN, ST_STEP: begin
                    if (hit) begin
                        state_q <= ST_DRAIN;
                        cause_q <= sel_cause;
                        dpc_q   <= sel_pc;
                        flush_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_idle || cnt_q == CNT_LAST) begin
                        state_q <= ST_HALTED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (dpc_wr_en) begin
                        dpc_q <= dpc_wr_data;
                    end
                    if (resumereq) begin
                        dbg_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        redir_q <= 1'b1;
                        state_q <= step ? ST_STEP : ST_RUN;
                    end else begin
                        dbg_q <= 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign dbg_mode    = dbg_q;
    assign halted      = dbg_q;
    assign resumeack   = ack_q;
    assign pipe_flush  = flush_q;
    assign pc_redirect = redir_q;
    assign redirect_pc = dpc_q;
    assign dpc         = dpc_q;
    assign dcsr_cause  = cause_q;

endmodule
